// File: rtl/msg_encryptor.sv
// Frame encryptor: wraps a message in space padding to a fixed 64-byte frame and
// XORs each byte with a 7-bit LFSR keystream, adding an even-parity bit 7.
module msg_encryptor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] msg_len,
    input  logic [3:0] pre_length,
    input  logic [6:0] lfsr_ptrn,
    input  logic [6:0] lfsr_init,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [5:0] out_idx,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    // Handshake: a byte moves on in_* or out_* in any cycle where valid and
    // ready are both high at the rising edge; valid never depends on ready.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        MSG  = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [6:0] FRAME_LEN = 7'd64;

    state_t     state;
    logic [6:0] idx;       // index of the next byte to be loaded
    logic [3:0] pre;
    logic [6:0] msg_end;
    logic [6:0] lfsr;
    logic [6:0] ptrn;

    logic [3:0] pre_clamp;
    logic [5:0] len_clamp;
    logic       can_load;
    logic       emit_space;
    logic       take_char;
    logic       load;
    logic       last_acc;
    logic [7:0] plain;
    logic [7:0] cipher;
    logic [6:0] lfsr_next;
    logic [6:0] idx_next;

    assign pre_clamp  = (pre_length < 4'd10) ? 4'd10 : pre_length;
    assign len_clamp  = (msg_len > 6'd49) ? 6'd49 : msg_len;

    assign can_load   = !out_valid || out_ready;
    assign in_ready   = (state == MSG) && can_load;
    assign take_char  = in_ready && in_valid;
    assign emit_space = ((state == PRE) || ((state == POST) && (idx != FRAME_LEN))) && can_load;
    assign load       = emit_space || take_char;
    assign last_acc   = out_valid && out_ready && (out_idx == 6'd63);
    assign idx_next   = idx + 7'd1;

    // Plaintext bit 7 is forced to zero, so reducing all 8 cipher bits
    // gives the parity of the 7 ciphertext bits.
    assign plain      = take_char ? (in_data & 8'h7f) : 8'h20;
    assign cipher     = plain ^ {1'b0, lfsr};
    assign lfsr_next  = {lfsr[5:0], ^(lfsr & ptrn)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pre       <= '0;
            msg_end   <= '0;
            lfsr      <= '0;
            ptrn      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // One keystream step per frame byte, taken as the byte enters the
            // output register; a held byte keeps its key because nothing reloads.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= {^cipher, cipher[6:0]};
                out_idx   <= idx[5:0];
                idx       <= idx_next;
                lfsr      <= lfsr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pre     <= pre_clamp;
                        msg_end <= {3'b000, pre_clamp} + {1'b0, len_clamp};
                        ptrn    <= lfsr_ptrn;
                        lfsr    <= (lfsr_init == 7'h00) ? 7'h01 : lfsr_init;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= PRE;
                    end
                end
                PRE: begin
                    if (load && (idx_next == {3'b000, pre})) begin
                        state <= (msg_end == {3'b000, pre}) ? POST : MSG;
                    end
                end
                MSG: begin
                    if (load && (idx_next == msg_end)) begin
                        state <= POST;
                    end
                end
                POST: begin
                    if (last_acc) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_encryptor.sv
// Bench for msg_encryptor: random frames and stalls checked against a
// frame-level model of the padding and keystream rules.
module tb_msg_encryptor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] msg_len;
    logic [3:0] pre_length;
    logic [6:0] lfsr_ptrn;
    logic [6:0] lfsr_init;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [5:0] out_idx;
    logic       out_ready;
    logic       busy;
    logic       done;

    msg_encryptor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
        .pre_length(pre_length), .lfsr_ptrn(lfsr_ptrn), .lfsr_init(lfsr_init),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] msg   [64];
    logic [7:0] exp_f [64];
    logic [7:0] act_f [64];
    logic [7:0] ref_f [64];
    int p_m, l_m;
    int acc_cnt, in_cnt, in_ptr, offered, first_ready;
    bit mon_en = 0, frame_done, pend_done, hold_prev;
    logic [7:0] hold_data;
    logic [5:0] hold_idx;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Frame model: padding positions, clamping and keystream from the rules.
    function automatic void build_model(input int p_raw, input int l_raw,
                                        input logic [6:0] ptrn, input logic [6:0] init);
        int key;
        int pl;
        int c;
        p_m = (p_raw < 10) ? 10 : p_raw;
        l_m = (l_raw > 49) ? 49 : l_raw;
        key = (init == 0) ? 1 : int'(init);
        for (int i = 0; i < 64; i++) begin
            if (i < p_m || i >= p_m + l_m) pl = 32;
            else pl = int'(msg[i - p_m]) % 128;
            c = (pl ^ key) % 128;
            exp_f[i] = 8'(c + 128 * ($countones(c) % 2));
            key = ((key * 2) % 128) + ($countones(key & int'(ptrn)) % 2);
        end
    endfunction

    // Compare process: one sample per cycle, just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_data));
                chk("hold_idx", 32'(out_idx), 32'(hold_idx));
            end
            chk("done", 32'(done), 32'(pend_done));
            pend_done = 0;
            chk("busy", 32'(busy), 32'd1);
            if (in_ready) begin
                if (first_ready < 0) first_ready = acc_cnt + int'(out_valid);
                chk("in_ready_window", 32'(acc_cnt + int'(out_valid)), 32'(p_m + in_cnt));
                chk("in_ready_count", 32'(in_cnt < l_m), 32'd1);
                if (in_valid) begin
                    in_cnt++;
                    in_ptr++;
                end
            end
            if (out_valid && out_ready) begin
                if (acc_cnt < 64) begin
                    chk("out_idx", 32'(out_idx), 32'(acc_cnt));
                    chk("out_data", 32'(out_data), 32'(exp_f[acc_cnt]));
                    act_f[acc_cnt] = out_data;
                    if (acc_cnt == 63) pend_done = 1;
                end else begin
                    chk("extra_byte", 32'(acc_cnt), 32'd63);
                end
                acc_cnt++;
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_idx  = out_idx;
            if (done) frame_done = 1;
        end
    end

    task automatic run_frame(input int p_raw, input int l_raw, input logic [6:0] ptrn,
                             input logic [6:0] init, input int offer, input bit stall,
                             input int abort_at);
        int cycles = 0;
        @(negedge clk);
        pre_length = 4'(p_raw);
        msg_len    = 6'(l_raw);
        lfsr_ptrn  = ptrn;
        lfsr_init  = init;
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        build_model(p_raw, l_raw, ptrn, init);
        acc_cnt = 0; in_cnt = 0; in_ptr = 0; offered = offer; first_ready = -1;
        frame_done = 0; pend_done = 0; hold_prev = 0;
        @(negedge clk);
        start = 1'b0;
        pre_length = 4'($urandom); msg_len = 6'($urandom);
        lfsr_ptrn = 7'($urandom); lfsr_init = 7'($urandom);
        mon_en = 1;
        while (1) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_ptr < offered) begin
                in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = msg[in_ptr];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            start = stall && ($urandom_range(0, 15) == 0);
            pre_length = 4'($urandom); msg_len = 6'($urandom);
            lfsr_ptrn = 7'($urandom); lfsr_init = 7'($urandom);
            @(negedge clk);
            if (frame_done) break;
            if (acc_cnt >= abort_at) begin
                mon_en = 0;
                start = 1'b0;
                in_valid = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_out_data", 32'(out_data), 32'd0);
                chk("abort_out_idx", 32'(out_idx), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    chk("post_abort_idle_valid", 32'(out_valid), 32'd0);
                    chk("post_abort_idle_busy", 32'(busy), 32'd0);
                    chk("post_abort_idle_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                return;
            end
            cycles++;
            if (cycles > 3000) begin
                chk("frame_timeout", 32'(acc_cnt), 32'd64);
                break;
            end
        end
        mon_en = 0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        chk("frame_bytes", 32'(acc_cnt), 32'd64);
        chk("frame_consumed", 32'(in_cnt), 32'(l_m));
    endtask

    initial begin
        string watson;
        rst_n = 1'b0; start = 1'b0; msg_len = '0; pre_length = '0;
        lfsr_ptrn = '0; lfsr_init = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-space frame, hand-computed first bytes.
        run_frame(10, 0, 7'h60, 7'h01, 0, 0, 999);
        chk("all_space_byte0", 32'(act_f[0]), 32'h21);
        chk("all_space_byte1", 32'(act_f[1]), 32'h22);
        for (int i = 0; i < 64; i++) ref_f[i] = act_f[i];

        // Zero seed behaves as seed 1.
        run_frame(10, 0, 7'h60, 7'h00, 0, 0, 999);
        for (int i = 0; i < 64; i++) chk("zero_seed_same", 32'(act_f[i]), 32'(ref_f[i]));

        // Short preamble clamps to 10.
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(0, 255));
        run_frame(3, 5, 7'h60, 7'h21, 5, 0, 999);
        chk("clamp_byte0", 32'(act_f[0]), 32'h81);
        chk("first_ready_idx", 32'(first_ready), 32'd10);

        // Overlong message clamps to 49 characters.
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(32, 126));
        run_frame(10, 60, 7'h41, 7'h5a, 60, 0, 999);
        chk("long_consumed", 32'(in_cnt), 32'd49);

        // Stalled run with a real message and ignored start pulses.
        watson = "Mr. Watson, come here. I want to see you.";
        for (int i = 0; i < watson.len(); i++) msg[i] = watson[i];
        run_frame(12, watson.len(), 7'($urandom), 7'($urandom), watson.len(), 1, 999);

        // Random settings and stalls.
        for (int f = 0; f < 4; f++) begin
            int l;
            for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(0, 255));
            l = $urandom_range(0, 63);
            run_frame($urandom_range(0, 15), l, 7'($urandom), 7'($urandom), l, 1, 999);
        end

        // Reset at index 30, then a complete new frame.
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(32, 126));
        run_frame(10, 30, 7'h60, 7'h13, 30, 1, 30);
        run_frame(11, 20, 7'h33, 7'h4c, 20, 1, 999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_encryptor.md
MSG_ENCRYPTOR -- requirements
Module: msg_encryptor

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to begin encrypting a message; sampled only in IDLE.
REQ-004 msg_len  input  6  message character count, latched at start.
REQ-005 pre_length  input  4  leading space count, latched at start.
REQ-006 lfsr_ptrn  input  7  LFSR feedback tap mask, latched at start.
REQ-007 lfsr_init  input  7  LFSR starting state, latched at start.
REQ-008 in_valid  input  1  upstream message character available.
REQ-009 in_data  input  8  upstream ASCII character.
REQ-010 in_ready  output  1  block accepts in_data this cycle when in_valid is also high.
REQ-011 out_valid  output  1  encrypted byte available on out_data.
REQ-012 out_data  output  8  encrypted byte; bit 7 is parity, bits 6:0 are ciphertext.
REQ-013 out_idx  output  6  frame position 0..63 of out_data.
REQ-014 out_ready  input  1  downstream (decrypt stage / data memory writer) accepts the byte.
REQ-015 busy  output  1  high from accepted start until done pulse.
REQ-016 done  output  1  one-cycle pulse after byte 63 is accepted.

Function
REQ-017 The block SHALL produce exactly 64 output bytes per run, indices 0..63 in order.
REQ-018 Latched pre_length below 10 SHALL be clamped to 10; latched msg_len above 49 SHALL be clamped to 49; msg_len 0 SHALL produce an all-space frame.
REQ-019 Latched lfsr_init of 0 SHALL be replaced by 7'h01.
REQ-020 The plaintext byte for index i SHALL be 8'h20 when i < P or i >= P+L (P, L clamped), otherwise the next accepted in_data.
REQ-021 Ciphertext bits 6:0 SHALL be plain[6:0] XOR lfsr; bit 7 SHALL be the XOR-reduction of the ciphertext bits 6:0; plain bit 7 SHALL be ignored.
REQ-022 The LFSR SHALL advance only when an output byte is accepted, as next = {lfsr[5:0], XOR-reduce(lfsr AND ptrn)}; byte 0 uses the initial state.
REQ-023 States: IDLE, PRE (emit leading spaces), MSG (consume input), POST (emit trailing spaces), DONE (pulse); PRE->MSG at index P, MSG->POST at index P+L, POST->DONE when byte 63 is accepted, DONE->IDLE after one cycle.
REQ-024 If L is 0, PRE SHALL go directly to POST.
REQ-025 The output register SHALL load when out_valid is low or out_ready is high; while out_valid is high and out_ready is low, out_data and out_idx SHALL hold stable.
REQ-026 in_ready SHALL be high only in MSG when the output register can load; sustained throughput SHALL be one byte per cycle.
REQ-027 Latency SHALL be one cycle: an input char accepted in cycle n appears on out_data in cycle n+1.
REQ-028 start SHALL be ignored while busy; in_valid outside MSG SHALL be ignored and not consumed.
REQ-029 Input and output stalls may occur in any combination; no byte SHALL be dropped or duplicated.

Reset
REQ-030 While rst_n is low, state SHALL be IDLE and out_valid, in_ready, busy, done, out_data, out_idx and lfsr SHALL be 0.
REQ-031 Reset asserted mid-run SHALL abort immediately; after release the block SHALL wait for a new start and emit no partial frame.

Verification
REQ-032 lfsr_init=7'h01, ptrn=7'h60, pre_length=10, msg_len=0, out_ready=1 -> out_data[0]=8'h21, out_data[1]=8'h22, 64 bytes, done one cycle after index 63.
REQ-033 lfsr_init=7'h00, other settings as in REQ-032 -> output identical to REQ-032.
REQ-034 lfsr_init=7'h21, pre_length=3 -> clamped to 10; out_data[0]=8'h81; first in_ready at index 10.
REQ-035 msg_len=60, 60 input chars offered -> exactly 49 consumed (indices 10..58), in_ready low afterward, indices 59..63 encrypt 8'h20.
REQ-036 Random out_ready/in_valid stalls with a "Mr. Watson" message -> frame matches the golden model byte for byte, out_data stable during stalls, start pulses while busy have no effect.
REQ-037 rst_n pulsed low at index 30 -> all outputs 0 immediately; a new start afterward produces a complete, correct 64-byte frame.
